// File: rtl/find_max_sched.sv
// Round-robin front end that shares one find_max engine between NREQ
// requesters. Each job is a burst of LEN words. The words pass straight to
// the engine, the engine's single result is captured, and the result is
// returned on the granted requester's response channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no job; arbitrate among requesters, grant on next edge
// FEED     | pass the granted requester's words through to the engine
// WAIT_RET | burst done; waiting for the engine result
// RESP     | result held on the granted requester's response channel
module find_max_sched #(
  parameter int          NREQ        = 4,
  parameter int          DATA_W      = 32,
  parameter int          LEN         = 8,
  parameter logic [15:0] JOB_CNT_RST = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_in_vld,
  output logic [NREQ-1:0]        req_in_busy,
  input  logic [NREQ*DATA_W-1:0] req_in_data,
  output logic [NREQ-1:0]        resp_out_vld,
  input  logic [NREQ-1:0]        resp_out_busy,
  output logic [DATA_W-1:0]      resp_out_data,
  output logic                   eng_x_vld,
  input  logic                   eng_x_busy,
  output logic [DATA_W-1:0]      eng_x_data,
  input  logic                   eng_ret_vld,
  output logic                   eng_ret_busy,
  input  logic [DATA_W-1:0]      eng_ret_data,
  output logic [2:0]             grant_id,
  output logic                   active,
  output logic [15:0]            job_count
);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT_RET, S_RESP} state_t;

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic [2:0]          r_last_grant;
  logic [2:0]          r_grant_id;
  logic [15:0]         r_job_count;
  logic [DATA_W-1:0]   r_result;

  logic                w_hi_any;
  logic                w_lo_any;
  logic [2:0]          w_hi;
  logic [2:0]          w_lo;
  logic                w_any_req;
  logic [2:0]          w_pick;
  logic                w_sel_vld;
  logic                w_sel_resp_busy;
  logic [DATA_W-1:0]   w_sel_data;
  logic [NREQ-1:0]     w_grant_oh;

  // Round-robin pick: lowest requester above last_grant, else wrap to the lowest one.
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi     = 3'd0;
    w_lo     = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_in_vld[i]) begin
        if ((3'(i) > r_last_grant) && !w_hi_any) begin
          w_hi_any = 1'b1;
          w_hi     = 3'(i);
        end
        if ((3'(i) <= r_last_grant) && !w_lo_any) begin
          w_lo_any = 1'b1;
          w_lo     = 3'(i);
        end
      end
    end
    w_any_req = w_hi_any | w_lo_any;
    w_pick    = w_hi_any ? w_hi : w_lo;
  end

  // Select the granted requester's channel signals.
  always_comb begin
    w_sel_vld       = 1'b0;
    w_sel_resp_busy = 1'b1;
    w_sel_data      = '0;
    w_grant_oh      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_sel_vld       = req_in_vld[i];
        w_sel_resp_busy = resp_out_busy[i];
        w_sel_data      = req_in_data[i*DATA_W +: DATA_W];
        w_grant_oh[i]   = 1'b1;
      end
    end
  end

  // Channel outputs decoded from state; FEED is a combinational pass-through.
  always_comb begin
    req_in_busy  = '1;
    eng_x_vld    = 1'b0;
    eng_x_data   = '0;
    eng_ret_busy = 1'b1;
    resp_out_vld = '0;
    case (r_state)
      S_FEED: begin
        eng_x_vld   = w_sel_vld;
        eng_x_data  = w_sel_data;
        req_in_busy = ~(w_grant_oh & {NREQ{~eng_x_busy}});
      end
      S_WAIT_RET: eng_ret_busy = 1'b0;
      S_RESP:     resp_out_vld = w_grant_oh;
      default: ;
    endcase
  end

  // Scheduler FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_last_grant <= 3'(NREQ - 1);
      r_grant_id   <= 3'd0;
      r_job_count  <= JOB_CNT_RST;
      r_result     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_id <= w_pick;
            r_cnt      <= 8'd0;
            r_state    <= S_FEED;
          end
        end
        S_FEED: begin
          if (w_sel_vld && !eng_x_busy) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == 8'(LEN - 1)) r_state <= S_WAIT_RET;
          end
        end
        S_WAIT_RET: begin
          if (eng_ret_vld) begin
            r_result <= eng_ret_data;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (!w_sel_resp_busy) begin
            r_last_grant <= r_grant_id;
            r_job_count  <= r_job_count + 16'd1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_id      = r_grant_id;
  assign active        = (r_state != S_IDLE);
  assign job_count     = r_job_count;
  assign resp_out_data = r_result;

endmodule

// File: doc/find_max_sched.md
Name: find_max_sched

Overview:
Round-robin scheduler that shares one find_max engine between NREQ requesters. A requester's job is a fixed burst of LEN data words. The scheduler grants one requester and streams that requester's words into the engine's x channel. It then captures the engine's single result from the return channel and delivers it to the granted requester's response channel. It sits between the requester channels and the engine x/return channels, inside dut.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 32, data word width
LEN, 8, words per job (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
req_in_vld  in  NREQ  per-requester word valid
req_in_busy  out  NREQ  per-requester stall (1 = cannot accept)
req_in_data  in  NREQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
resp_out_vld  out  NREQ  per-requester result valid
resp_out_busy  in  NREQ  per-requester result stall
resp_out_data  out  DATA_W  result, shared; qualified by resp_out_vld
eng_x_vld  out  1  engine input word valid
eng_x_busy  in  1  engine input stall
eng_x_data  out  DATA_W  engine input word
eng_ret_vld  in  1  engine result valid
eng_ret_busy  out  1  engine result stall
eng_ret_data  in  DATA_W  engine result
grant_id  out  3  index of current/last granted requester
active  out  1  1 while a job is in progress (state != IDLE)
job_count  out  16  completed jobs, wraps 0xFFFF->0

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-low.
- Handshake on every channel: a transfer occurs on a rising edge where vld=1 and busy=0. A producer holds vld and data stable until the transfer occurs.
- Reset (rst=0 at an edge): state=IDLE, cnt=0, last_grant=NREQ-1, grant_id=0, job_count=0, result reg=0.
- Reset output values: req_in_busy=all 1, resp_out_vld=0, resp_out_data=0, eng_x_vld=0, eng_x_data=0, eng_ret_busy=1, active=0.
- Reset applies from any state. A job in flight is abandoned, and the engine is expected to be reset alongside.
- FSM states: IDLE, FEED, WAIT_RET, RESP.
- IDLE:
  - All req_in_busy=1, eng_x_vld=0, eng_ret_busy=1.
  - If any req_in_vld is set, pick the first set bit searching from last_grant+1 upward, modulo NREQ.
  - On the next edge: grant_id <= pick, cnt <= 0, go to FEED.
  - No request: stay in IDLE.
  - Grant latency is 1 cycle from vld seen to FEED.
- FEED: pass-through from the granted requester g.
  - eng_x_vld = req_in_vld[g], eng_x_data = req_in_data[g], req_in_busy[g] = eng_x_busy.
  - Non-granted req_in_busy=1.
  - Each transfer increments cnt. On the transfer where cnt==LEN-1, go to WAIT_RET.
  - If the requester deasserts vld mid-burst, the job stalls indefinitely and the grant is held.
- WAIT_RET:
  - eng_x_vld=0, all req_in_busy=1, eng_ret_busy=0.
  - On eng_ret_vld: result reg <= eng_ret_data, go to RESP.
- RESP:
  - eng_ret_busy=1, resp_out_vld[g]=1, other resp_out_vld bits 0, resp_out_data=result reg.
  - On a transfer (resp_out_busy[g]=0): last_grant <= g, job_count++, go to IDLE.
  - While resp_out_busy[g]=1, vld and data are held stable and no new grant is issued.
- eng_ret_vld outside WAIT_RET is never accepted because eng_ret_busy=1.
- resp_out_data retains its last value outside RESP.
- Width rules:
  - cnt is 8 bits; LEN=1 goes to WAIT_RET after the first transfer.
  - grant_id is zero-extended to 3 bits.
  - job_count wraps modulo 2^16 with no saturation.
- Fairness: a requester that has just been served has lowest priority on the next arbitration. With all NREQ requesting, grants rotate 0,1,...,NREQ-1,0.
- Datapath registers (result reg, cnt, last_grant, grant_id) are flops. Channel outputs in FEED are combinational from the requester and engine signals.

Test Plan:
- Single job: after reset, req0 sends 8 words 3,9,1,7,2,0,5,4 with eng_x_busy=0.
  - Required: eng_x_data carries the same sequence, and req_in_busy[0]=0 only in FEED.
  - Engine returns 9: resp_out_vld[0]=1 with resp_out_data=9, then job_count=1 and active=0.
- Contention: all 4 requesters hold vld with a distinct job each.
  - Required: grant_id sequence 0,1,2,3,0, and each resp_out_vld bit pulses only for its own requester.
- Backpressure: eng_x_busy toggles 1/0 every cycle during FEED with words 10..17.
  - Required: the engine receives exactly 10..17 in order, with no duplicates or drops.
  - Required: WAIT_RET is entered only after 8 transfers.
- Response stall: resp_out_busy[2]=1 for 5 cycles in RESP, with req1 also requesting.
  - Required: resp_out_vld[2] and resp_out_data are held stable, and there is no new grant until release.
  - Required: the next grant goes to req3 if req3 is requesting, else wraps round to req1.
- Reset mid-job: assert rst=0 after 4 of 8 words have transferred from req1.
  - Required: all outputs take their reset values.
  - Required: after release, with req1 and req0 both requesting, the first grant is req0.
- Counter wrap: preload or run 65536 jobs with LEN=1.
  - Required: job_count goes 0xFFFF -> 0x0000, and the scheduler keeps serving.
